// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit
// per clock. Both work on operand magnitudes and fix the sign in the final step.
// Divide-by-zero and signed overflow complete one cycle after accept.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;    // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd;   // multiplicand or divisor magnitude
  logic              neg_q;  // product / quotient sign
  logic              neg_r;  // remainder sign
  logic [XLEN-1:0]   res;

  // Request decode on the live inputs (only used at the accept edge)
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] early_res;
  logic            accept;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic              last;
  logic [CNT_W-1:0]  cnt_inc;

  assign busy   = (state == S_MUL) || (state == S_DIV);
  assign done   = (state == S_DONE);
  assign result = res;

  // Decode operand signedness, magnitudes and the early-completion cases
  always_comb begin
    is_div   = funct3[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (is_div) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3 == 3'b001) || (funct3 == 3'b010);
      b_signed = (funct3 == 3'b001);
    end
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && ~funct3[0] &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // Overflow DIV returns the dividend itself (0x80000000), overflow REM returns 0
    if (funct3[1])
      early_res = div_zero ? a : '0;
    else
      early_res = div_zero ? '1 : a;
    accept = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // One shift-add step and its sign-corrected form for the final iteration
  always_comb begin
    if (acc[0])
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    else
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    mul_fix  = neg_q ? (~mul_next + 1'b1) : mul_next;
  end

  // One restoring-division step and sign-corrected quotient/remainder
  always_comb begin
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[XLEN])
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    quot_fix = neg_q ? (~div_next[XLEN-1:0] + 1'b1) : div_next[XLEN-1:0];
    rem_fix  = neg_r ? (~div_next[2*XLEN-1:XLEN] + 1'b1) : div_next[2*XLEN-1:XLEN];
  end

  // Iteration counter bookkeeping; saturates at XLEN rather than wrapping
  always_comb begin
    last    = (cnt == CNT_W'(XLEN - 1));
    cnt_inc = (cnt == CNT_W'(XLEN)) ? cnt : cnt + 1'b1;
  end

  // Control state, operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op    <= funct3;
            cnt   <= '0;
            opnd  <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero || div_ovf) begin
              acc   <= '0;
              res   <= early_res;
              state <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, a_mag};
              state <= is_div ? S_DIV : S_MUL;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt_inc;
          if (last) begin
            res   <= (op[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
            state <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt_inc;
          if (last) begin
            res   <= op[1] ? rem_fix : quot_fix;
            state <= S_DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: the stimulus process pushes
// expected result and completion cycle; a monitor pops and compares on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    logic [2:0]  f;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    logic [63:0] pu;
    int          sx;
    int          sy;
    logic        ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin pu = {32'b0, x} * {32'b0, y}; return pu[31:0]; end
      3'd1: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      3'd2: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done result=%h cyc=%0d", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (result !== e.res) begin
          bad++;
          $display("FAIL result f=%0d got=%h want=%h", e.f, result, e.res);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL latency f=%0d got_cyc=%0d want_cyc=%0d", e.f, cyc, e.cyc);
        end
      end
    end
  end

  // Drive one request (caller is at negedge+1); afterwards scramble inputs
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit track);
    exp_t e;
    bit   early;
    early  = f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    start  = 1'b1;
    funct3 = f;
    a      = x;
    b      = y;
    if (track) begin
      e.res = ref_res(f, x, y);
      e.cyc = cyc + 1 + (early ? 0 : 32);
      e.f   = f;
      q.push_back(e);
      last_res = e.res;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    a      = $urandom;
    b      = $urandom;
    if (track) check("busy_after_accept", {31'b0, busy}, {31'b0, !early});
  endtask

  // Wait until the scoreboard drains; leaves caller at negedge+1 of the DONE cycle
  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    issue(f, x, y, 1'b1);
    drain();
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    rst    = 1'b0;
    start  = 1'b0;
    funct3 = '0;
    a      = '0;
    b      = '0;

    // Reset, then abort a multiply at E10
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    issue(3'd0, 32'd7, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    check("busy_mid_op", {31'b0, busy}, 32'd1);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    run(3'd0, 32'd7, 32'd6);

    // Multiply variants on all-ones operands
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Signed and unsigned divide/remainder of -7 by 2
    run(3'd4, 32'hFFFF_FFF9, 32'd2);
    run(3'd6, 32'hFFFF_FFF9, 32'd2);
    run(3'd5, 32'hFFFF_FFF9, 32'd2);
    run(3'd7, 32'hFFFF_FFF9, 32'd2);

    // Early-completion corners
    run(3'd5, 32'd5, 32'd0);
    run(3'd6, 32'd5, 32'd0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start while busy is ignored; then back-to-back start from DONE
    issue(3'd0, 32'd3, 32'd5, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    start  = 1'b1;
    funct3 = 3'd4;
    a      = 32'd9;
    b      = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ignores_start", {31'b0, busy}, 32'd1);
    drain();
    check("mul_3x5_held", result, 32'd15);
    issue(3'd5, 32'd9, 32'd3, 1'b1);
    repeat (10) @(negedge clk);
    check("result_held_while_busy", result, 32'd15);
    drain();

    // Randomized operations with occasional idle gaps
    for (int i = 0; i < 60; i++) begin
      int unsigned mode;
      mode = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom;
      case (mode)
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 100); y = $urandom_range(1, 20); end
        3: begin x = -$urandom_range(0, 100); y = $urandom_range(1, 20); end
        4: y = -$urandom_range(1, 20);
        default: ;
      endcase
      run(3'($urandom_range(0, 7)), x, y);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(2, 5)) @(negedge clk);
        check("idle_result_held", result, last_res);
        check("idle_done_low", {31'b0, done}, 32'd0);
        #1;
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. It sits directly downstream of the register file's read ports and consumes the two read operands (RD1 → a, RD2 → b).
- It produces a 32-bit result that the writeback mux selects into the register file write data (WD3).
- The core control holds the PC and suppresses WE3 while busy is high, then writes result when done pulses.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must hold XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset (0 = reset, sampled on posedge clk)
- start  input  1  request strobe, sampled on posedge
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  operand rs1 (from RD1)
- b  input  32  operand rs2 (from RD2)
- busy  output  1  high while iterating
- done  output  1  one-cycle result-valid pulse
- result  output  32  result; held stable until the next accepted start

Behaviour:
- Reset: on a posedge with rst=0, the unit enters IDLE and forces busy=0, done=0, result=0, counter=0 and internal accumulators to 0.
  - Reset aborts any operation in flight; no done pulse follows.
- State machine has four states:
  - IDLE: busy=0, done=0.
  - MUL: busy=1.
  - DIV: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept rule: start is accepted only in IDLE or DONE (this allows back-to-back ops). start during MUL/DIV is ignored; funct3, a and b changes are also ignored there.
- Operand capture: a, b and funct3 are registered at the accept edge E0. They are not sampled again.
- Signedness:
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU and MUL: unsigned magnitudes.
  - DIV/REM: signed. DIVU/REMU: unsigned.
  - For signed ops, convert to magnitudes at E0 and record the result sign.
- Multiply path (E0 → MUL):
  - Radix-2 shift-add over a 64-bit product register, one bit per edge E1..E32.
  - At E32, apply the sign correction (two's-complement negate of the 64-bit product if the sign flag is set), load result, and go to DONE.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide path (E0 → DIV):
  - Restoring division on magnitudes, one quotient bit per edge E1..E32.
  - At E32, apply signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Load result (quotient for DIV/DIVU, remainder for REM/REMU) and go to DONE.
- Latency: normal ops show done=1 in the cycle after E32 (33 edges after accept). DONE returns to IDLE at the next edge unless a new start is accepted.
- Divide-by-zero (b==0), detected at E0, goes straight to DONE (done one cycle after accept) with:
  - DIV/DIVU: result = 0xFFFFFFFF.
  - REM/REMU: result = a.
- Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF), detected at E0, goes straight to DONE with:
  - DIV: result = 0x80000000.
  - REM: result = 0.
- Simultaneous reset and start: reset wins.
- A start accepted in DONE re-enters MUL/DIV; done drops at that edge.
- The counter saturates logic at XLEN. There is no wrap; the counter clears on every accept.
- result updates only on entry to DONE and is otherwise held.

Test Plan:
- Reset mid-operation:
  - Stimulus: rst=0 for 2 cycles, start MUL a=7 b=6, then drop rst=0 at E10.
  - Required: busy=0, done=0, result=0 after reset. No done pulse for the aborted op.
  - Then release rst and start MUL a=7 b=6: done exactly 33 edges after accept, result=42.
- Multiply high variants, a=0xFFFFFFFF b=0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
  - MUL → 0x00000001.
- Signed divide/remainder, a=-7 (0xFFFFFFF9) b=2:
  - DIV → 0xFFFFFFFD (-3).
  - REM → 0xFFFFFFFF (-1).
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Corner cases, each with done one cycle after accept:
  - b=0, DIVU a=5 → 0xFFFFFFFF.
  - b=0, REM a=5 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Start while busy:
  - Stimulus: MUL a=3 b=5, then pulse start with funct3=100 a=9 b=3 at E5.
  - Required: ignored; result=15 at done.
  - Back-to-back: start DIVU a=9 b=3 during the DONE cycle → busy rises at that edge, later result=3, and result=15 stays held until then.
